// File: rtl/spi_bridge.sv
// SPI mode-0 slave front-end: oversamples sclk/cs_n/mosi in clk, emits byte_sync/data_rx, serialises data_tx on miso.
// Define SPI_BRIDGE_LSB_FIRST_EN for LSB-first on both lines; MSB-first otherwise.
module spi_bridge (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       byte_sync,
    output logic [7:0] data_rx,
    input  logic [7:0] data_tx,
    output logic       abort
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       cs_s1, cs_s2, cs_s3;
    logic       mosi_s1, mosi_s2;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic       done_q, done_d;
    logic       reload_q, reload_d;
    logic       abort_d;
    logic       rise_det, fall_det, cs_fall_det, cs_rise_det;
    logic [7:0] rx_shifted, tx_shifted;

    assign rise_det    = sclk_s2 & ~sclk_s3;
    assign fall_det    = ~sclk_s2 & sclk_s3;
    assign cs_fall_det = ~cs_s2 & cs_s3;
    assign cs_rise_det = cs_s2 & ~cs_s3;

    // miso is the outgoing end of the tx shift register, so it is a flop output
`ifdef SPI_BRIDGE_LSB_FIRST_EN
    assign rx_shifted = {mosi_s2, rx_q[7:1]};
    assign tx_shifted = {1'b0, tx_q[7:1]};
    assign miso       = tx_q[0];
`else
    assign rx_shifted = {rx_q[6:0], mosi_s2};
    assign tx_shifted = {tx_q[6:0], 1'b0};
    assign miso       = tx_q[7];
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        reload_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cs_fall_det) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = 3'd0;
                    rx_d      = 8'h00;
                    tx_d      = data_tx;
                end
            end
            ACTIVE: begin
                if (cs_rise_det) begin
                    // chip-select release wins over any coincident sclk edge or pending reload
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                    tx_d      = 8'h00;
                    abort_d   = (bit_cnt_q != 3'd0);
                end else begin
                    reload_d = byte_sync;
                    if (reload_q) begin
                        tx_d = data_tx;
                    end
                    if (rise_det) begin
                        rx_d      = rx_shifted;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        done_d    = (bit_cnt_q == 3'd7);
                    end else if (fall_det && bit_cnt_q != 3'd0) begin
                        tx_d = tx_shifted;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_s3   <= 1'b0;
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            cs_s3     <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            done_q    <= 1'b0;
            reload_q  <= 1'b0;
            byte_sync <= 1'b0;
            data_rx   <= 8'h00;
            abort     <= 1'b0;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_s3   <= sclk_s2;
            cs_s1     <= cs_n;
            cs_s2     <= cs_s1;
            cs_s3     <= cs_s2;
            mosi_s1   <= mosi;
            mosi_s2   <= mosi_s1;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            reload_q  <= reload_d;
            byte_sync <= done_q;
            abort     <= abort_d;
            if (done_q) begin
                data_rx <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_spi_bridge.sv
// Directed + randomized bench for spi_bridge: SPI master model at fclk = 8 x fsclk, expected bytes from plain queues.
module tb_spi_bridge;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic [7:0] data_tx = 8'h00;
    logic       miso;
    logic       byte_sync;
    logic [7:0] data_rx;
    logic       abort;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] rx_log[$];
    int         abort_cnt = 0;
    int         overlap_cnt = 0;
    logic [7:0] f_mosi[4];
    logic [7:0] f_dtx[5];
    logic       first_bit;

    spi_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .byte_sync (byte_sync),
        .data_rx   (data_rx),
        .data_tx   (data_tx),
        .abort     (abort)
    );

    initial forever #5 clk = ~clk;

    always @(negedge clk) begin
        if (byte_sync) rx_log.push_back(data_rx);
        if (abort) abort_cnt++;
        if (byte_sync && abort) overlap_cnt++;
    end

    function automatic int bit_idx(input int i);
`ifdef SPI_BRIDGE_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one byte: master drives mosi on the falling edge, samples miso on the rising edge
    task automatic spi_byte(input logic [7:0] mo, input logic [7:0] next_tx, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mosi = mo[bit_idx(i)];
            #40;
            sclk = 1'b1;
            mi[bit_idx(i)] = miso;
            if (i == 0) first_bit = miso;
            if (i == 7) begin
                #30;
                check("sync_not_early", {31'd0, byte_sync}, 32'd0);
                #10;
                check("sync_4_cycles", {31'd0, byte_sync}, 32'd1);
                data_tx = next_tx;
            end else begin
                #40;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int n);
        int base;
        int ab;
        logic [7:0] got;
        base = rx_log.size();
        ab = abort_cnt;
        data_tx = f_dtx[0];
        #20;
        cs_n = 1'b0;
        #40;
        for (int k = 0; k < n; k++) begin
            spi_byte(f_mosi[k], f_dtx[k+1], got);
            check("miso_byte", {24'd0, got}, {24'd0, f_dtx[k]});
        end
        #40;
        cs_n = 1'b1;
        #80;
        check("sync_count", rx_log.size(), base + n);
        for (int k = 0; k < n; k++) begin
            if (base + k < rx_log.size())
                check("rx_byte", {24'd0, rx_log[base+k]}, {24'd0, f_mosi[k]});
        end
        check("no_abort", abort_cnt, ab);
        check("rx_held", {24'd0, data_rx}, {24'd0, f_mosi[n-1]});
    endtask

    initial begin
        int base;
        int ab;
        int n;

        #20;
        check("rst_miso", {31'd0, miso}, 32'd0);
        check("rst_sync", {31'd0, byte_sync}, 32'd0);
        check("rst_data_rx", {24'd0, data_rx}, 32'd0);
        check("rst_abort", {31'd0, abort}, 32'd0);
        #20;
        rst_n = 1'b1;
        #60;

        // write frame
        f_mosi[0] = 8'h85; f_mosi[1] = 8'h3C;
        f_dtx[0] = 8'($urandom); f_dtx[1] = 8'($urandom); f_dtx[2] = 8'($urandom);
        run_frame(2);

        // read frame with decoder response
        f_mosi[0] = 8'($urandom); f_mosi[1] = 8'($urandom);
        f_dtx[0] = 8'hA5; f_dtx[1] = 8'h5A; f_dtx[2] = 8'h00;
        run_frame(2);

        // randomized frames
        for (int fr = 0; fr < 6; fr++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) f_mosi[k] = 8'($urandom);
            for (int k = 0; k < 5; k++) f_dtx[k] = 8'($urandom);
            run_frame(n);
        end

        // partial byte then cs release
        data_tx = 8'($urandom);
        #20;
        cs_n = 1'b0;
        #40;
        for (int i = 0; i < 5; i++) begin
            mosi = 1'($urandom);
            #40; sclk = 1'b1;
            #40; sclk = 1'b0;
        end
        #40;
        ab = abort_cnt;
        base = rx_log.size();
        cs_n = 1'b1;
        #20;
        check("abort_not_early", {31'd0, abort}, 32'd0);
        #10;
        check("abort_3_cycles", {31'd0, abort}, 32'd1);
        check("miso_idle", {31'd0, miso}, 32'd0);
        #40;
        check("abort_once", abort_cnt, ab + 1);
        check("partial_no_sync", rx_log.size(), base);
        f_mosi[0] = 8'hFF; f_dtx[0] = 8'($urandom); f_dtx[1] = 8'($urandom);
        run_frame(1);

        // sclk activity outside a frame
        base = rx_log.size();
        for (int i = 0; i < 4; i++) begin
            #40; sclk = 1'b1;
            #40; sclk = 1'b0;
        end
        #80;
        check("idle_edges_ignored", rx_log.size(), base);
        f_mosi[0] = 8'hC3; f_dtx[0] = 8'($urandom); f_dtx[1] = 8'($urandom);
        run_frame(1);

        // reset mid-byte
        data_tx = 8'hFF;
        #20;
        cs_n = 1'b0;
        #40;
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #40; sclk = 1'b1;
            #40; sclk = 1'b0;
        end
        #20;
        check("pre_rst_miso", {31'd0, miso}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_miso", {31'd0, miso}, 32'd0);
        check("midrst_sync", {31'd0, byte_sync}, 32'd0);
        check("midrst_data_rx", {24'd0, data_rx}, 32'd0);
        check("midrst_abort", {31'd0, abort}, 32'd0);
        #9;
        cs_n = 1'b1;
        #20;
        rst_n = 1'b1;
        #40;
        f_mosi[0] = 8'h01; f_dtx[0] = 8'($urandom); f_dtx[1] = 8'($urandom);
        run_frame(1);

        // single-bit byte in both directions
        f_mosi[0] = 8'h01; f_dtx[0] = 8'h01; f_dtx[1] = 8'($urandom);
        run_frame(1);
        check("first_miso_bit", {31'd0, first_bit}, {31'd0, f_dtx[0][bit_idx(0)]});

        check("sync_abort_overlap", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_bridge.md
# spi_bridge

SPI slave front-end for the PWM generator. It oversamples the external SPI pins (mode 0, CPOL=0/CPHA=0) in the `clk` domain and assembles MOSI bytes. Each complete byte is presented to the instruction decoder as a one-cycle `byte_sync` strobe with `data_rx`. The decoder's response byte `data_tx` is serialised back on MISO.

## Interface
- Parameters: none.
- `clk`  in  1  peripheral clock; must satisfy fclk ≥ 8 × fsclk.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `sclk`  in  1  SPI clock from master, asynchronous to `clk`; idles low.
- `cs_n`  in  1  SPI chip select, active-low, asynchronous.
- `mosi`  in  1  master-out data, asynchronous.
- `miso`  out  1  slave-out data, registered.
- `byte_sync`  out  1  one-cycle pulse: `data_rx` holds a complete byte.
- `data_rx`  out  8  last received byte; held until the next byte completes.
- `data_tx`  in  8  byte to transmit next, sourced from the decoder's `data_out`.
- `abort`  out  1  one-cycle pulse: frame ended with a partial byte.

## Operation
- Synchronisers:
  - `sclk`, `cs_n` and `mosi` each pass through a 2-FF synchroniser of identical depth, so the three stay aligned.
  - A third register on `sclk` and on `cs_n` provides edge detection: rise_det, fall_det, cs_fall_det, cs_rise_det.
- States:
  - IDLE (cs_n synced high) → on cs_fall_det, go to ACTIVE. Actions: bit_cnt = 0, rx_shift = 0, tx_shift = `data_tx`, `miso` = `data_tx[7]`.
  - ACTIVE → on cs_rise_det, go to IDLE. Actions: bit_cnt = 0, `miso` = 0. If bit_cnt ≠ 0, pulse `abort` and discard the partial byte; no `byte_sync`.
- ACTIVE, on rise_det:
  - rx_shift = {rx_shift[6:0], mosi_sync}; bit_cnt increments modulo 8 (3 bits, wraps 7→0).
  - When bit_cnt wraps 7→0: on the next cycle `data_rx` = the assembled byte and `byte_sync` = 1 for exactly one cycle.
- ACTIVE, on fall_det:
  - If bit_cnt ≠ 0: tx_shift shifts left and `miso` = the new tx_shift[7].
  - If bit_cnt = 0 (byte boundary): ignored, because `miso` already carries the next byte's MSB.
- Tx reload at a byte boundary:
  - Two cycles after `byte_sync` rises, tx_shift = `data_tx` and `miso` = `data_tx[7]`.
  - This gives the decoder one cycle to register `data_out`.
- Simultaneous events:
  - cs_rise_det takes priority over rise_det/fall_det in the same cycle; the edge is ignored.
  - A pending tx reload is cancelled by cs_rise_det.
- Outside a frame, sclk edges are ignored.

## Timing
- Reset values: `miso` = 0, `byte_sync` = 0, `data_rx` = 8'h00, `abort` = 0. Internal state: IDLE, bit_cnt = 0, shift registers = 0.
- Pin sclk rising edge (8th bit) → `byte_sync` high: 4 clk cycles (2 sync + 1 detect/shift + 1 output register).
- `byte_sync` → tx reload visible on `miso`: 2 clk cycles. Total from the 8th pin rising edge: 6 cycles, which fits within one sclk period at fclk ≥ 8 × fsclk.
- Pin sclk falling edge → `miso` update: 3 clk cycles, which is under half an sclk period.
- Pin cs_n rising edge → `abort`: 3 clk cycles.
- `byte_sync` and `abort` are never high in the same cycle.
- Reset mid-frame: all outputs return to reset values immediately. After `rst_n` deasserts, cs_n must return high before a new frame is recognised; the block needs a cs_fall_det.

## Configuration
- `SPI_BRIDGE_LSB_FIRST_EN`:
  - Defined: LSB-first on both lines. rx_shift = {mosi_sync, rx_shift[7:1]}; tx shifts right; `miso` = tx_shift[0]; loads drive `miso` = `data_tx[0]`.
  - Undefined (default): MSB-first as described above.

## Test plan
- Write frame, MSB-first. Stimulus: cs_n low, MOSI bytes 8'h85 then 8'h3C, fclk = 8 × fsclk. Required: two `byte_sync` pulses with `data_rx` = 8'h85 then 8'h3C; `abort` stays 0.
- Read frame. Stimulus: `data_tx` = 8'hA5 before cs_n falls, and the decoder model drives `data_tx` = 8'h5A one cycle after the first `byte_sync`. Required: master samples 8'hA5 in byte 1 and 8'h5A in byte 2.
- Partial byte. Stimulus: cs_n low, 5 sclk cycles, cs_n high. Required: no `byte_sync`, exactly one `abort` pulse, `miso` = 0 afterwards, next frame decodes 8'hFF correctly.
- Reset mid-byte. Stimulus: assert `rst_n` low after 3 bits. Required: all outputs 0 at once; after release plus a fresh frame with byte 8'h01, `data_rx` = 8'h01.
- Edge ignore. Stimulus: toggle sclk 4 times with cs_n high, then a frame with byte 8'hC3. Required: no `byte_sync` before the frame; `data_rx` = 8'hC3.
- With `SPI_BRIDGE_LSB_FIRST_EN`. Stimulus: MOSI bit sequence 1,0,0,0,0,0,0,0; `data_tx` = 8'h01. Required: `data_rx` = 8'h01; first MISO bit = 1.
